// File: rtl/sdram_bist_engine.sv
// Self-test traffic generator for the sdram_controller SoC port: writes a pattern over an
// address window, reads it back, compares, and reports pass/fail, error count and first error.
module sdram_bist_engine #(
    parameter int                    ADDR_WIDTH     = 23,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR     = '0,
    parameter int                    NUM_WORDS      = 1024,
    parameter int                    TIMEOUT_CYCLES = 4096,
    parameter logic [31:0]           LFSR_SEED      = 32'hACE1
) (
    input  logic                  clk,
    input  logic                  reset_pin,
    input  logic                  start_pin,
    input  logic [1:0]            pattern_sel_pin,
    output logic                  busy_pin,
    output logic                  done_pin,
    output logic                  pass_pin,
    output logic                  timeout_pin,
    output logic [15:0]           error_count_pin,
    output logic [ADDR_WIDTH-1:0] first_err_addr_pin,
    output logic [31:0]           first_err_data_pin,
    input  logic                  ctrl_busy_pin,
    input  logic                  ctrl_ready_pin,
    output logic [ADDR_WIDTH-1:0] ctrl_addr_pin,
    output logic [31:0]           ctrl_wr_data_pin,
    output logic [3:0]            ctrl_wr_mask_pin,
    output logic                  ctrl_wr_en_pin,
    output logic                  ctrl_rd_en_pin,
    input  logic [31:0]           ctrl_rd_data_pin
);
    localparam int              IW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int              TW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_WORDS - 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_INIT, S_WR_ISSUE, S_WR_WAIT_HI,
        S_WR_WAIT_LO, S_RD_ISSUE, S_RD_WAIT, S_DONE
    } state_t;

    // Galois form of x^32+x^22+x^2+x+1, shifting right.
    function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    function automatic logic [31:0] f_pattern(input logic [1:0] mode, input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [4:0] bitpos, input logic [31:0] lfsr);
        case (mode)
            2'd0:    return 32'(addr);
            2'd1:    return lfsr;
            2'd2:    return 32'h0000_0001 << bitpos;
            2'd3:    return ~(32'(addr));
            default: return 32'(addr);
        endcase
    endfunction

    state_t                r_state;
    logic [1:0]            r_mode;
    logic [IW-1:0]         r_idx;
    logic [4:0]            r_bit;
    logic [ADDR_WIDTH-1:0] r_addr_cur;
    logic [31:0]           r_lfsr;
    logic [TW-1:0]         r_tmo_cnt;
    logic                  r_err_seen;
    logic                  r_busy, r_done, r_pass, r_timeout;
    logic [15:0]           r_err_cnt;
    logic [ADDR_WIDTH-1:0] r_first_addr, r_ctrl_addr;
    logic [31:0]           r_first_data, r_wr_data;
    logic                  r_wr_en, r_rd_en;

    logic [31:0] w_pattern;
    logic        w_last, w_mismatch, w_wait_met, w_abort;

    assign w_pattern  = f_pattern(r_mode, r_addr_cur, r_bit, r_lfsr);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_mismatch = (ctrl_rd_data_pin != w_pattern);

    // Handshake condition each state is waiting on; meeting it always changes state.
    always_comb begin
        w_wait_met = 1'b1;
        case (r_state)
            S_WAIT_INIT, S_WR_ISSUE, S_WR_WAIT_LO, S_RD_ISSUE: w_wait_met = !ctrl_busy_pin;
            S_WR_WAIT_HI: w_wait_met = ctrl_busy_pin;
            S_RD_WAIT:    w_wait_met = ctrl_ready_pin;
            default:      w_wait_met = 1'b1;
        endcase
    end

    assign w_abort = (r_state != S_IDLE) && (r_state != S_DONE) && !w_wait_met && (r_tmo_cnt == TMO_LAST);

    // Main sequencer: command issue, read compare, status capture.
    always_ff @(posedge clk or posedge reset_pin) begin
        if (reset_pin) begin
            r_state      <= S_IDLE;
            r_mode       <= 2'd0;
            r_idx        <= '0;
            r_bit        <= 5'd0;
            r_addr_cur   <= '0;
            r_lfsr       <= LFSR_SEED;
            r_tmo_cnt    <= '0;
            r_err_seen   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_err_cnt    <= 16'd0;
            r_first_addr <= '0;
            r_first_data <= 32'd0;
            r_ctrl_addr  <= '0;
            r_wr_data    <= 32'd0;
            r_wr_en      <= 1'b0;
            r_rd_en      <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_done    <= 1'b0;
            r_tmo_cnt <= (r_state == S_IDLE || w_wait_met) ? '0 : r_tmo_cnt + TW'(1);
            if (w_abort) begin
                r_timeout <= 1'b1;
                r_pass    <= 1'b0;
                r_done    <= 1'b1;
                r_tmo_cnt <= '0;
                r_state   <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_pin) begin
                            r_mode       <= pattern_sel_pin;
                            r_busy       <= 1'b1;
                            r_err_cnt    <= 16'd0;
                            r_err_seen   <= 1'b0;
                            r_first_addr <= '0;
                            r_first_data <= 32'd0;
                            r_timeout    <= 1'b0;
                            r_pass       <= 1'b0;
                            r_idx        <= '0;
                            r_bit        <= 5'd0;
                            r_addr_cur   <= START_ADDR;
                            r_lfsr       <= LFSR_SEED;
                            r_state      <= S_WAIT_INIT;
                        end
                    end
                    S_WAIT_INIT: if (w_wait_met) r_state <= S_WR_ISSUE;
                    S_WR_ISSUE: begin
                        if (w_wait_met) begin
                            r_wr_en     <= 1'b1;
                            r_ctrl_addr <= r_addr_cur;
                            r_wr_data   <= w_pattern;
                            r_state     <= S_WR_WAIT_HI;
                        end
                    end
                    S_WR_WAIT_HI: if (w_wait_met) r_state <= S_WR_WAIT_LO;
                    S_WR_WAIT_LO: begin
                        if (w_wait_met) begin
                            if (w_last) begin
                                // Read phase replays the same sequence from the beginning.
                                r_idx      <= '0;
                                r_bit      <= 5'd0;
                                r_addr_cur <= START_ADDR;
                                r_lfsr     <= LFSR_SEED;
                                r_state    <= S_RD_ISSUE;
                            end else begin
                                r_idx      <= r_idx + IW'(1);
                                r_bit      <= r_bit + 5'd1;
                                r_addr_cur <= r_addr_cur + ADDR_WIDTH'(1);
                                r_lfsr     <= f_lfsr_step(r_lfsr);
                                r_state    <= S_WR_ISSUE;
                            end
                        end
                    end
                    S_RD_ISSUE: begin
                        if (w_wait_met) begin
                            r_rd_en     <= 1'b1;
                            r_ctrl_addr <= r_addr_cur;
                            r_state     <= S_RD_WAIT;
                        end
                    end
                    S_RD_WAIT: begin
                        if (w_wait_met) begin
                            if (w_mismatch) begin
                                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                                if (!r_err_seen) begin
                                    r_err_seen   <= 1'b1;
                                    r_first_addr <= r_addr_cur;
                                    r_first_data <= ctrl_rd_data_pin;
                                end
                            end
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_pass  <= (r_err_cnt == 16'd0) && !w_mismatch;
                                r_state <= S_DONE;
                            end else begin
                                r_idx      <= r_idx + IW'(1);
                                r_bit      <= r_bit + 5'd1;
                                r_addr_cur <= r_addr_cur + ADDR_WIDTH'(1);
                                r_lfsr     <= f_lfsr_step(r_lfsr);
                                r_state    <= S_RD_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy_pin           = r_busy;
    assign done_pin           = r_done;
    assign pass_pin           = r_pass;
    assign timeout_pin        = r_timeout;
    assign error_count_pin    = r_err_cnt;
    assign first_err_addr_pin = r_first_addr;
    assign first_err_data_pin = r_first_data;
    assign ctrl_addr_pin      = r_ctrl_addr;
    assign ctrl_wr_data_pin   = r_wr_data;
    assign ctrl_wr_mask_pin   = 4'b0000;
    assign ctrl_wr_en_pin     = r_wr_en;
    assign ctrl_rd_en_pin     = r_rd_en;

endmodule

// File: tb/tb_sdram_bist_engine.sv
// Bench for sdram_bist_engine: behavioural SDRAM-port model plus a scoreboard of expected
// write/read commands, and directed runs covering all patterns, corruption, wrap, timeout, reset.
module tb_sdram_bist_engine;
    localparam int          AW   = 23;
    localparam logic [22:0] SA   = 23'h7FFFFE;
    localparam int          NW   = 40;
    localparam int          TMO  = 64;
    localparam logic [31:0] SEED = 32'hACE1;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  sel;
    logic        busy, done, pass, tmo;
    logic [15:0] ecnt;
    logic [22:0] faddr, caddr;
    logic [31:0] fdata, wdata, rdata;
    logic [3:0]  wmask;
    logic        wr_en, rd_en;
    logic        m_busy, m_ready, m_stuck, m_corr5, m_corr9;
    logic [2:0]  m_bcnt, m_rcnt;
    logic [22:0] m_raddr;

    typedef struct { logic [22:0] a; logic [31:0] d; } wr_t;
    wr_t         q_wr[$];
    logic [22:0] q_rd[$];
    logic [31:0] mem [logic [22:0]];
    int n_cmp = 0, n_bad = 0, n_done = 0;

    always #5 clk = ~clk;

    sdram_bist_engine #(.ADDR_WIDTH(AW), .START_ADDR(SA), .NUM_WORDS(NW),
                        .TIMEOUT_CYCLES(TMO), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset_pin(rst), .start_pin(start), .pattern_sel_pin(sel),
        .busy_pin(busy), .done_pin(done), .pass_pin(pass), .timeout_pin(tmo),
        .error_count_pin(ecnt), .first_err_addr_pin(faddr), .first_err_data_pin(fdata),
        .ctrl_busy_pin(m_busy), .ctrl_ready_pin(m_ready), .ctrl_addr_pin(caddr),
        .ctrl_wr_data_pin(wdata), .ctrl_wr_mask_pin(wmask), .ctrl_wr_en_pin(wr_en),
        .ctrl_rd_en_pin(rd_en), .ctrl_rd_data_pin(rdata));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic logic [31:0] exp_pat(input logic [1:0] m, input int i, input logic [22:0] a,
                                            input logic [31:0] l);
        case (m)
            2'd0:    return {9'd0, a};
            2'd1:    return l;
            2'd2:    return 32'd1 << (i % 32);
            default: return ~{9'd0, a};
        endcase
    endfunction

    // Memory array of the port model.
    always @(posedge clk) if (wr_en) mem[caddr] = wdata;

    // Port model: busy for 3 cycles per command, read data valid 6 cycles after rd_en.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_bcnt <= 3'd0; m_rcnt <= 3'd0;
            m_raddr <= 23'd0; rdata <= 32'd0;
        end else begin
            m_ready <= 1'b0;
            if (wr_en || rd_en) begin
                m_busy <= 1'b1; m_bcnt <= 3'd3;
            end else if (m_bcnt != 3'd0) begin
                m_bcnt <= m_bcnt - 3'd1;
                m_busy <= m_stuck || (m_bcnt > 3'd1);
            end
            if (rd_en) begin
                m_rcnt <= 3'd5; m_raddr <= caddr;
            end else if (m_rcnt != 3'd0) begin
                m_rcnt <= m_rcnt - 3'd1;
                if (m_rcnt == 3'd1) begin
                    m_ready <= 1'b1;
                    rdata <= ((m_corr5 && m_raddr == 23'd5) || (m_corr9 && m_raddr == 23'd9))
                             ? 32'hDEAD_BEEF : mem[m_raddr];
                end
            end
        end
    end

    // Scoreboard: pop and compare every command the engine issues.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            chk("wr_while_busy", {31'd0, m_busy}, 32'd0);
            chk("wr_mask", {28'd0, wmask}, 32'd0);
            if (q_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else begin
                chk("wr_addr", {9'd0, caddr}, {9'd0, q_wr[0].a});
                chk("wr_data", wdata, q_wr[0].d);
                void'(q_wr.pop_front());
            end
        end
        if (!rst && rd_en) begin
            chk("rd_while_busy", {31'd0, m_busy}, 32'd0);
            if (q_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else chk("rd_addr", {9'd0, caddr}, {9'd0, q_rd.pop_front()});
        end
        if (done) n_done++;
    end

    task automatic build(input logic [1:0] m);
        logic [31:0] l;
        logic [22:0] a;
        q_wr.delete(); q_rd.delete();
        l = SEED;
        for (int i = 0; i < NW; i++) begin
            a = SA + 23'(i);
            q_wr.push_back('{a: a, d: exp_pat(m, i, a, l)});
            q_rd.push_back(a);
            l = lfsr_next(l);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_tmo"}, {31'd0, tmo}, 32'd0);
        chk({tag, "_ecnt"}, {16'd0, ecnt}, 32'd0);
        chk({tag, "_faddr"}, {9'd0, faddr}, 32'd0);
        chk({tag, "_fdata"}, fdata, 32'd0);
        chk({tag, "_caddr"}, {9'd0, caddr}, 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
        chk({tag, "_en"}, {30'd0, wr_en, rd_en}, 32'd0);
    endtask

    task automatic kick(input logic [1:0] m);
        build(m);
        n_done = 0;
        sel = m; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [1:0] m, input int bound, input logic [15:0] e_cnt,
                       input logic [22:0] e_fa, input logic [31:0] e_fd, input logic e_pass,
                       input logic e_tmo);
        bit seen;
        kick(m);
        repeat (19) @(negedge clk);
        sel = ~m; start = 1'b1;                      // must be ignored while running
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) chk({tag, "_done_wait"}, 32'd0, 32'd1);
        else begin
            chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
            chk({tag, "_pass"}, {31'd0, pass}, {31'd0, e_pass});
            chk({tag, "_timeout"}, {31'd0, tmo}, {31'd0, e_tmo});
            chk({tag, "_ecnt"}, {16'd0, ecnt}, {16'd0, e_cnt});
            chk({tag, "_faddr"}, {9'd0, faddr}, {9'd0, e_fa});
            chk({tag, "_fdata"}, fdata, e_fd);
            repeat (3) @(negedge clk);
            chk({tag, "_done_once"}, 32'(n_done), 32'd1);
            chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
            chk({tag, "_pass_held"}, {31'd0, pass}, {31'd0, e_pass});
            if (!e_tmo) chk({tag, "_sb_empty"}, 32'(q_wr.size() + q_rd.size()), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 2'd0;
        m_stuck = 1'b0; m_corr5 = 1'b0; m_corr9 = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run("mode0", 2'd0, 3000, 16'd0, 23'd0, 32'd0, 1'b1, 1'b0);
        m_corr5 = 1'b1;
        run("corrupt5", 2'd0, 3000, 16'd1, 23'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        m_corr9 = 1'b1;
        run("corrupt59", 2'd0, 3000, 16'd2, 23'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        m_corr5 = 1'b0; m_corr9 = 1'b0;
        run("mode1", 2'd1, 3000, 16'd0, 23'd0, 32'd0, 1'b1, 1'b0);
        run("mode2", 2'd2, 3000, 16'd0, 23'd0, 32'd0, 1'b1, 1'b0);
        run("mode3", 2'd3, 3000, 16'd0, 23'd0, 32'd0, 1'b1, 1'b0);

        // Reset in the middle of the read phase.
        kick(2'd0);
        for (int c = 0; c < 3000 && q_rd.size() > NW - 3; c++) @(negedge clk);
        chk("midrd_reached", 32'(q_rd.size() <= NW - 3), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("midrd_reset");
        @(negedge clk); rst = 1'b0;
        q_wr.delete(); q_rd.delete();
        @(negedge clk);
        run("after_reset", 2'd1, 3000, 16'd0, 23'd0, 32'd0, 1'b1, 1'b0);

        m_stuck = 1'b1;
        run("timeout", 2'd0, TMO + 20, 16'd0, 23'd0, 32'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
